// File: rtl/cdb_arbiter.sv
// Result writeback arbiter: per-producer FIFOs feed NUM_PORTS registered broadcast slots, round-robin.
// Optional macro CDB_LSU_PRIO_EN: the LSU (requester NUM_REQ-1) always takes slot 0 when it has a result.
module cdb_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned TAG_W      = 6
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        flush,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ*TAG_W-1:0]    req_prd,
   input  logic [NUM_REQ*TAG_W-1:0]    req_rob,
   input  logic [NUM_REQ-1:0]          req_wr,
   output logic [NUM_PORTS-1:0]        out_valid,
   output logic [NUM_PORTS*DATA_W-1:0] out_data,
   output logic [NUM_PORTS*TAG_W-1:0]  out_prd,
   output logic [NUM_PORTS*TAG_W-1:0]  out_rob,
   output logic [NUM_PORTS-1:0]        out_wr,
   output logic [NUM_PORTS*2-1:0]      out_src,
   output logic                        busy
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned SRC_W = 2;
   localparam int unsigned LSU   = NUM_REQ - 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  prd;
      logic [TAG_W-1:0]  rob;
      logic              wr;
   } entry_t;

   entry_t             mem     [NUM_REQ][FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr  [NUM_REQ];
   logic [PTR_W-1:0]   wr_ptr  [NUM_REQ];
   logic [CNT_W-1:0]   count   [NUM_REQ];
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   rr_nxt;
   logic [IDX_W-1:0]   scan_i;
   logic [NUM_REQ-1:0] nonempty;
   logic [NUM_REQ-1:0] push;
   logic [NUM_REQ-1:0] pop;
   logic               found;
   logic [NUM_PORTS-1:0] gnt_vld;
   logic [IDX_W-1:0]   gnt_idx [NUM_PORTS];
   entry_t             gnt_ent [NUM_PORTS];

   function automatic logic [IDX_W-1:0] scan_idx(input logic [IDX_W-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      return IDX_W'(s % NUM_REQ);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Occupancy-only handshake: a same-cycle pop never raises ready.
   always_comb begin
      nonempty  = '0;
      req_ready = '0;
      push      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         nonempty[i]  = (count[i] != '0);
         req_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
         push[i]      = req_valid[i] && req_ready[i];
      end
   end

   // Fill slots in scan order from rr_ptr; a requester already popped this cycle is skipped.
   always_comb begin
      gnt_vld = '0;
      pop     = '0;
      rr_nxt  = rr_ptr;
      found   = 1'b0;
      scan_i  = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         gnt_idx[k] = '0;
         gnt_ent[k] = '0;
      end
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         found = 1'b0;
`ifdef CDB_LSU_PRIO_EN
         if (k == 0 && nonempty[LSU]) begin
            gnt_vld[k] = 1'b1;
            gnt_idx[k] = IDX_W'(LSU);
            pop[LSU]   = 1'b1;
            found      = 1'b1;
         end
`endif
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            scan_i = scan_idx(rr_ptr, j);
            if (!found && nonempty[scan_i] && !pop[scan_i]) begin
               gnt_vld[k]  = 1'b1;
               gnt_idx[k]  = scan_i;
               pop[scan_i] = 1'b1;
               found       = 1'b1;
               rr_nxt      = scan_idx(scan_i, 1);
            end
         end
      end
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         if (gnt_vld[k]) gnt_ent[k] = mem[gnt_idx[k]][rd_ptr[gnt_idx[k]]];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (push[i] && !flush) begin
            mem[i][wr_ptr[i]] <= '{data: req_data[i*DATA_W +: DATA_W],
                                   prd:  req_prd[i*TAG_W +: TAG_W],
                                   rob:  req_rob[i*TAG_W +: TAG_W],
                                   wr:   req_wr[i]};
         end
      end
   end

   // FIFO pointers, occupancy and round-robin pointer; flush beats push/pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rr_ptr <= '0;
      end else if (flush) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rr_ptr <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
            if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
            if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
            else if (pop[i] && !push[i]) count[i] <= count[i] - CNT_W'(1);
         end
         rr_ptr <= rr_nxt;
      end
   end

   // Registered broadcast slots; unused slots carry all-zero fields.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= '0;
         out_data  <= '0;
         out_prd   <= '0;
         out_rob   <= '0;
         out_wr    <= '0;
         out_src   <= '0;
      end else if (flush) begin
         out_valid <= '0;
         out_data  <= '0;
         out_prd   <= '0;
         out_rob   <= '0;
         out_wr    <= '0;
         out_src   <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            out_valid[k]                  <= gnt_vld[k];
            out_data[k*DATA_W +: DATA_W]  <= gnt_ent[k].data;
            out_prd[k*TAG_W +: TAG_W]     <= gnt_ent[k].prd;
            out_rob[k*TAG_W +: TAG_W]     <= gnt_ent[k].rob;
            out_wr[k]                     <= gnt_ent[k].wr;
            out_src[k*SRC_W +: SRC_W]     <= SRC_W'(gnt_idx[k]);
         end
      end
   end

   assign busy = (|nonempty) | (|out_valid);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations follow CDB_LSU_PRIO_EN when it is defined.
`timescale 1ns/1ps
module tb_cdb_arbiter;
   localparam int unsigned NUM_REQ   = 4;
   localparam int unsigned NUM_PORTS = 2;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned TAG_W     = 6;
`ifdef CDB_LSU_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic                        clk = 1'b0;
   logic                        reset_n;
   logic                        flush;
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ*DATA_W-1:0]   req_data;
   logic [NUM_REQ*TAG_W-1:0]    req_prd;
   logic [NUM_REQ*TAG_W-1:0]    req_rob;
   logic [NUM_REQ-1:0]          req_wr;
   logic [NUM_PORTS-1:0]        out_valid;
   logic [NUM_PORTS*DATA_W-1:0] out_data;
   logic [NUM_PORTS*TAG_W-1:0]  out_prd;
   logic [NUM_PORTS*TAG_W-1:0]  out_rob;
   logic [NUM_PORTS-1:0]        out_wr;
   logic [NUM_PORTS*2-1:0]      out_src;
   logic                        busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .req_prd(req_prd), .req_rob(req_rob), .req_wr(req_wr),
      .out_valid(out_valid), .out_data(out_data), .out_prd(out_prd),
      .out_rob(out_rob), .out_wr(out_wr), .out_src(out_src), .busy(busy)
   );

   function automatic logic [31:0] slot_data(input int unsigned k);
      return out_data[k*DATA_W +: DATA_W];
   endfunction

   function automatic logic [1:0] slot_src(input int unsigned k);
      return out_src[k*2 +: 2];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      req_valid = '0;
      req_data  = '0;
      req_prd   = '0;
      req_rob   = '0;
      req_wr    = '0;
   endtask

   task automatic set_req(input int unsigned i, input logic [31:0] d, input logic [5:0] prd,
                          input logic [5:0] rob, input logic wr);
      req_valid[i]                = 1'b1;
      req_data[i*DATA_W +: DATA_W] = d;
      req_prd[i*TAG_W +: TAG_W]   = prd;
      req_rob[i*TAG_W +: TAG_W]   = rob;
      req_wr[i]                   = wr;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      flush   = 1'b0;
      clear_req();
      req_valid = 4'b1111;
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (out_valid !== 2'b00) begin fails++; $display("FAIL reset_out_valid: got %b exp 00", out_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
      req_valid = '0;
      reset_n   = 1'b1;
      step();
      tests++; if (req_ready !== 4'b1111) begin fails++; $display("FAIL reset_ready: got %b exp 1111", req_ready); end
      tests++; if (out_valid !== 2'b00) begin fails++; $display("FAIL reset_idle_valid: got %b exp 00", out_valid); end
   endtask

   task automatic test_single();
      set_req(1, 32'hDEADBEEF, 6'd12, 6'd5, 1'b1);
      step();
      clear_req();
      tests++; if (out_valid !== 2'b00) begin fails++; $display("FAIL single_latency: got %b exp 00", out_valid); end
      step();
      tests++; if (out_valid !== 2'b01) begin fails++; $display("FAIL single_valid: got %b exp 01", out_valid); end
      tests++; if (slot_data(0) !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got %h exp deadbeef", slot_data(0)); end
      tests++; if (out_prd[5:0] !== 6'd12) begin fails++; $display("FAIL single_prd: got %0d exp 12", out_prd[5:0]); end
      tests++; if (out_rob[5:0] !== 6'd5) begin fails++; $display("FAIL single_rob: got %0d exp 5", out_rob[5:0]); end
      tests++; if (out_wr !== 2'b01) begin fails++; $display("FAIL single_wr: got %b exp 01", out_wr); end
      tests++; if (slot_src(0) !== 2'd1) begin fails++; $display("FAIL single_src: got %0d exp 1", slot_src(0)); end
      tests++; if (slot_data(1) !== 32'h0 || out_prd[11:6] !== 6'd0) begin fails++; $display("FAIL single_unused_slot: got %h/%0d exp 0/0", slot_data(1), out_prd[11:6]); end
      step();
      tests++; if (out_valid !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL single_drain: got %b/%b exp 00/0", out_valid, busy); end
      // rr_ptr now 2: scan 2,3,0 puts the LSU ahead of FU0 (same order under LSU priority)
      set_req(0, 32'hA0A0_0000, 6'd1, 6'd1, 1'b1);
      set_req(3, 32'hA3A3_0003, 6'd2, 6'd2, 1'b0);
      step();
      clear_req();
      step();
      tests++; if (slot_src(0) !== 2'd3 || slot_src(1) !== 2'd0) begin fails++; $display("FAIL single_rr2_src: got %0d,%0d exp 3,0", slot_src(0), slot_src(1)); end
      tests++; if (slot_data(0) !== 32'hA3A3_0003 || slot_data(1) !== 32'hA0A0_0000 || out_wr !== 2'b10) begin
         fails++; $display("FAIL single_rr2_data: got %h,%h wr %b exp a3a30003,a0a00000 wr 10", slot_data(0), slot_data(1), out_wr); end
      step();
   endtask

   task automatic test_four();
      logic [1:0] e1 [2];
      logic [1:0] e2 [2];
      e1[0] = PRIO ? 2'd3 : 2'd0;  e1[1] = PRIO ? 2'd0 : 2'd1;
      e2[0] = PRIO ? 2'd1 : 2'd2;  e2[1] = PRIO ? 2'd2 : 2'd3;
      do_flush();
      for (int unsigned i = 0; i < NUM_REQ; i++) set_req(i, 32'h1111_0000 + i, 6'(i + 8), 6'(i + 20), 1'b1);
      step();
      clear_req();
      step();
      tests++; if (out_valid !== 2'b11) begin fails++; $display("FAIL four_valid1: got %b exp 11", out_valid); end
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         tests++; if (slot_src(k) !== e1[k] || slot_data(k) !== 32'h1111_0000 + 32'(e1[k])) begin
            fails++; $display("FAIL four_b1_slot%0d: got src %0d data %h exp src %0d", k, slot_src(k), slot_data(k), e1[k]); end
      end
      step();
      tests++; if (out_valid !== 2'b11) begin fails++; $display("FAIL four_valid2: got %b exp 11", out_valid); end
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         tests++; if (slot_src(k) !== e2[k] || slot_data(k) !== 32'h1111_0000 + 32'(e2[k])) begin
            fails++; $display("FAIL four_b2_slot%0d: got src %0d data %h exp src %0d", k, slot_src(k), slot_data(k), e2[k]); end
      end
      step();
      tests++; if (out_valid !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL four_drain: got %b/%b exp 00/0", out_valid, busy); end
      // Plain round-robin left rr_ptr at 0, so FU1 precedes the LSU
      set_req(1, 32'h2222_0001, 6'd3, 6'd3, 1'b1);
      set_req(3, 32'h2222_0003, 6'd4, 6'd4, 1'b1);
      step();
      clear_req();
      step();
      tests++; if (slot_src(0) !== (PRIO ? 2'd3 : 2'd1) || slot_src(1) !== (PRIO ? 2'd1 : 2'd3)) begin
         fails++; $display("FAIL four_rr_wrap: got %0d,%0d exp %0d,%0d", slot_src(0), slot_src(1), PRIO ? 3 : 1, PRIO ? 1 : 3); end
      step();
   endtask

   task automatic test_full();
      logic [31:0] sb [NUM_REQ][$];
      int          gap [NUM_REQ];
      bit          saw_block;
      logic [1:0]  s;
      logic [31:0] d;
      int          bound;
      do_flush();
      saw_block = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin sb[i].delete(); gap[i] = 0; end
      for (int c = 0; c < 32; c++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) gap[i]++;
         for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (out_valid[k]) begin
               s = slot_src(k);
               gap[s] = 0;
               tests++;
               if (sb[s].size() == 0) begin
                  fails++; $display("FAIL full_unexpected: cycle %0d slot %0d src %0d data %h, none pending", c, k, s, slot_data(k));
               end else begin
                  if (slot_data(k) !== sb[s][0]) begin
                     fails++; $display("FAIL full_data: cycle %0d src %0d got %h exp %h", c, s, slot_data(k), sb[s][0]); end
                  void'(sb[s].pop_front());
               end
            end
         end
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            tests++; if (req_ready[i] !== (sb[i].size() != 2)) begin
               fails++; $display("FAIL full_ready%0d: cycle %0d got %b exp %b", i, c, req_ready[i], sb[i].size() != 2); end
            if (c >= 4 && c < 24) begin
               bound = PRIO ? ((i == 3) ? 0 : 2) : 1;
               tests++; if (gap[i] > bound) begin
                  fails++; $display("FAIL full_fair%0d: cycle %0d ungranted for %0d exp <= %0d", i, c, gap[i], bound); end
            end
         end
         if (req_ready[0] === 1'b0) saw_block = 1'b1;
         clear_req();
         if (c < 24) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               d = 32'(i * 32'h0100_0000) + 32'(c);
               set_req(i, d, 6'(i), 6'(c), 1'b1);
               if (req_ready[i]) sb[i].push_back(d);
            end
         end
         step();
      end
      clear_req();
      tests++; if (!saw_block) begin fails++; $display("FAIL full_block: got ready0 never low exp low at count 2"); end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         tests++; if (sb[i].size() != 0) begin fails++; $display("FAIL full_lost%0d: got %0d undelivered exp 0", i, sb[i].size()); end
      end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_idle: got busy %b exp 0", busy); end
   endtask

   task automatic test_flush();
      do_flush();
      set_req(0, 32'h5150_0000, 6'd1, 6'd1, 1'b1);
      set_req(1, 32'h5150_0001, 6'd2, 6'd2, 1'b1);
      set_req(2, 32'h5150_0002, 6'd3, 6'd3, 1'b1);
      step();
      clear_req();
      set_req(3, 32'hBAD0_BAD0, 6'd9, 6'd9, 1'b1);
      flush = 1'b1;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_busy_before: got %b exp 1", busy); end
      step();
      flush = 1'b0;
      clear_req();
      tests++; if (out_valid !== 2'b00) begin fails++; $display("FAIL flush_valid: got %b exp 00", out_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy: got %b exp 0", busy); end
      tests++; if (req_ready !== 4'b1111) begin fails++; $display("FAIL flush_ready: got %b exp 1111", req_ready); end
      for (int c = 0; c < 3; c++) begin
         step();
         tests++; if (out_valid !== 2'b00 || out_data !== '0) begin
            fails++; $display("FAIL flush_stale: cycle %0d got %b data %h exp 00 data 0", c, out_valid, out_data); end
      end
   endtask

   task automatic test_lsu_prio();
      do_flush();
      set_req(0, 32'h7000_0000, 6'd1, 6'd1, 1'b1);
      set_req(2, 32'h7000_0002, 6'd2, 6'd2, 1'b1);
      set_req(3, 32'h7000_0003, 6'd3, 6'd3, 1'b1);
      step();
      clear_req();
      step();
      tests++; if (out_valid !== 2'b11 || slot_src(0) !== (PRIO ? 2'd3 : 2'd0) || slot_src(1) !== (PRIO ? 2'd0 : 2'd2)) begin
         fails++; $display("FAIL prio_first: got %b src %0d,%0d exp 11 src %0d,%0d", out_valid, slot_src(0), slot_src(1), PRIO ? 3 : 0, PRIO ? 0 : 2); end
      step();
      tests++; if (out_valid !== 2'b01 || slot_src(0) !== (PRIO ? 2'd2 : 2'd3)) begin
         fails++; $display("FAIL prio_second: got %b src %0d exp 01 src %0d", out_valid, slot_src(0), PRIO ? 2 : 3); end
      tests++; if (slot_data(0) !== (PRIO ? 32'h7000_0002 : 32'h7000_0003)) begin
         fails++; $display("FAIL prio_second_data: got %h exp %h", slot_data(0), PRIO ? 32'h7000_0002 : 32'h7000_0003); end
      step();
      tests++; if (out_valid !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL prio_drain: got %b/%b exp 00/0", out_valid, busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_four();
      test_full();
      test_flush();
      test_lsu_prio();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
